wb_reg_file: RTL

WB_REG_FILE -- requirements
Module: wb_reg_file

---
 rtl/wb_reg_file.sv | 61 ++++++
 1 files changed

// File: rtl/wb_reg_file.sv
// wb_reg_file: write-back stage register file with write-through bypass,
// forwarding record of the last write and a committed-write counter.
module wb_reg_file #(
    parameter int DATA_W = 16,
    parameter int NREG = 16,
    localparam int AW = $clog2(NREG)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRegWrite,
    input  logic              IRegStore,
    input  logic [DATA_W-1:0] IALUResult,
    input  logic [DATA_W-1:0] IStoreMem,
    input  logic [15:0]       IRd,
    input  logic              WBEnable,
    input  logic [AW-1:0]     Rs1,
    input  logic [AW-1:0]     Rs2,
    output logic [DATA_W-1:0] RData1,
    output logic [DATA_W-1:0] RData2,
    output logic              OWBValid,
    output logic [AW-1:0]     OWBRd,
    output logic [DATA_W-1:0] OWBData,
    output logic [15:0]       OWriteCount
);
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     rd;
    logic              commit;
    logic              unused_rd;

    assign unused_rd = ^IRd[15:AW];
    assign rd = IRd[AW-1:0];
    assign wdata = IRegStore ? IStoreMem : IALUResult;
    assign commit = WBEnable && IRegWrite && rd != '0 && !Reset;

    // a write landing this cycle is visible on the read ports immediately
    always_comb begin
        RData1 = Rs1 == '0 ? '0 : (commit && Rs1 == rd) ? wdata : regs[Rs1];
        RData2 = Rs2 == '0 ? '0 : (commit && Rs2 == rd) ? wdata : regs[Rs2];
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            OWBValid <= 1'b0;
            OWBRd <= '0;
            OWBData <= '0;
            OWriteCount <= '0;
        end else begin
            if (commit) begin
                regs[rd] <= wdata;
                OWriteCount <= OWriteCount + 16'd1;
            end
            if (WBEnable) begin
                OWBValid <= commit;
                OWBRd <= rd;
                OWBData <= wdata;
            end
        end
    end
endmodule
